// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_arbiter
// Brief    : 2:1 AXI-Lite arbiter (m0 = IFU read-only, m1 = LSU read/write)
//            sharing one slave port; one transaction outstanding at a time.
// Config   : ARB_ROUND_ROBIN_EN -> round-robin on m0/m1 contention,
//            otherwise fixed priority with m1 winning.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // m0: instruction fetch, read only
  input  logic              m0_ar_valid_i,
  input  logic [ADDR_W-1:0] m0_ar_addr_i,
  output logic              m0_ar_ready_o,
  output logic              m0_r_valid_o,
  output logic [DATA_W-1:0] m0_r_data_o,
  output logic [1:0]        m0_r_resp_o,
  input  logic              m0_r_ready_i,
  // m1: load/store, read + write
  input  logic              m1_ar_valid_i,
  input  logic [ADDR_W-1:0] m1_ar_addr_i,
  output logic              m1_ar_ready_o,
  output logic              m1_r_valid_o,
  output logic [DATA_W-1:0] m1_r_data_o,
  output logic [1:0]        m1_r_resp_o,
  input  logic              m1_r_ready_i,
  input  logic              m1_aw_valid_i,
  input  logic [ADDR_W-1:0] m1_aw_addr_i,
  output logic              m1_aw_ready_o,
  input  logic              m1_w_valid_i,
  input  logic [DATA_W-1:0] m1_w_data_i,
  input  logic [STRB_W-1:0] m1_w_strb_i,
  output logic              m1_w_ready_o,
  output logic              m1_b_valid_o,
  output logic [1:0]        m1_b_resp_o,
  input  logic              m1_b_ready_i,
  // shared slave port
  output logic              s_ar_valid_o,
  output logic [ADDR_W-1:0] s_ar_addr_o,
  input  logic              s_ar_ready_i,
  input  logic              s_r_valid_i,
  input  logic [DATA_W-1:0] s_r_data_i,
  input  logic [1:0]        s_r_resp_i,
  output logic              s_r_ready_o,
  output logic              s_aw_valid_o,
  output logic [ADDR_W-1:0] s_aw_addr_o,
  input  logic              s_aw_ready_i,
  output logic              s_w_valid_o,
  output logic [DATA_W-1:0] s_w_data_o,
  output logic [STRB_W-1:0] s_w_strb_o,
  input  logic              s_w_ready_i,
  input  logic              s_b_valid_i,
  input  logic [1:0]        s_b_resp_i,
  output logic              s_b_ready_o,
  output logic [1:0]        grant_o
);

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_M0_RD  = 4'b0010;
  localparam logic [3:0] ST_M1_RD  = 4'b0100;
  localparam logic [3:0] ST_M1_WR  = 4'b1000;

  logic [3:0] r_state;
  logic [3:0] w_state_nxt;
  logic       r_last_m1;
  logic       w_last_m1_nxt;
  logic       w_req0;
  logic       w_req1;
  logic       w_pick_m1;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_last_m1 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_m1 <= w_last_m1_nxt;
    end
  end

  assign w_req0 = m0_ar_valid_i;
  assign w_req1 = m1_ar_valid_i | m1_aw_valid_i;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the master that lost the previous arbitration wins.
  assign w_pick_m1 = w_req1 & (~w_req0 | ~r_last_m1);
`else
  assign w_pick_m1 = w_req1;
  logic w_unused_last_m1;
  assign w_unused_last_m1 = r_last_m1;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_last_m1_nxt = r_last_m1;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_m1) begin
          // A pending m1 read is served ahead of a pending m1 write.
          w_state_nxt   = m1_ar_valid_i ? ST_M1_RD : ST_M1_WR;
          w_last_m1_nxt = 1'b1;
        end else if (w_req0) begin
          w_state_nxt   = ST_M0_RD;
          w_last_m1_nxt = 1'b0;
        end
      end
      ST_M0_RD: if (s_r_valid_i && m0_r_ready_i) w_state_nxt = ST_IDLE;
      ST_M1_RD: if (s_r_valid_i && m1_r_ready_i) w_state_nxt = ST_IDLE;
      ST_M1_WR: if (s_b_valid_i && m1_b_ready_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_o       = 2'b00;
    m0_ar_ready_o = 1'b0;
    m0_r_valid_o  = 1'b0;
    m0_r_data_o   = '0;
    m0_r_resp_o   = 2'b00;
    m1_ar_ready_o = 1'b0;
    m1_r_valid_o  = 1'b0;
    m1_r_data_o   = '0;
    m1_r_resp_o   = 2'b00;
    m1_aw_ready_o = 1'b0;
    m1_w_ready_o  = 1'b0;
    m1_b_valid_o  = 1'b0;
    m1_b_resp_o   = 2'b00;
    s_ar_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    s_r_ready_o   = 1'b0;
    s_aw_valid_o  = 1'b0;
    s_aw_addr_o   = '0;
    s_w_valid_o   = 1'b0;
    s_w_data_o    = '0;
    s_w_strb_o    = '0;
    s_b_ready_o   = 1'b0;
    case (r_state)
      ST_M0_RD: begin
        grant_o       = 2'b01;
        s_ar_valid_o  = m0_ar_valid_i;
        s_ar_addr_o   = m0_ar_addr_i;
        m0_ar_ready_o = s_ar_ready_i;
        m0_r_valid_o  = s_r_valid_i;
        m0_r_data_o   = s_r_data_i;
        m0_r_resp_o   = s_r_resp_i;
        s_r_ready_o   = m0_r_ready_i;
      end
      ST_M1_RD: begin
        grant_o       = 2'b10;
        s_ar_valid_o  = m1_ar_valid_i;
        s_ar_addr_o   = m1_ar_addr_i;
        m1_ar_ready_o = s_ar_ready_i;
        m1_r_valid_o  = s_r_valid_i;
        m1_r_data_o   = s_r_data_i;
        m1_r_resp_o   = s_r_resp_i;
        s_r_ready_o   = m1_r_ready_i;
      end
      ST_M1_WR: begin
        // AW and W pass through independently; the master drops each valid
        // after its own handshake, so no per-channel tracking is needed.
        grant_o       = 2'b10;
        s_aw_valid_o  = m1_aw_valid_i;
        s_aw_addr_o   = m1_aw_addr_i;
        m1_aw_ready_o = s_aw_ready_i;
        s_w_valid_o   = m1_w_valid_i;
        s_w_data_o    = m1_w_data_i;
        s_w_strb_o    = m1_w_strb_i;
        m1_w_ready_o  = s_w_ready_i;
        m1_b_valid_o  = s_b_valid_i;
        m1_b_resp_o   = s_b_resp_i;
        s_b_ready_o   = m1_b_ready_i;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
